// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: definitions shared by the fetch stage and the control FSM.
//   state_e    - fetch FSM states (FETCH, HOLD, HALT)
//   XLEN       - datapath / address width
//   HALT_INSTR - instruction word that stops the machine; the control FSM
//                decodes the same constant so both stages agree on it
package fetch_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] HALT_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the instruction-memory request bus and the
// instruction hand-off to the decoder.
//   imem_req/imem_addr        - read request (fetch -> memory)
//   imem_rdata/imem_ack       - read completion (memory -> fetch)
//   instr/instr_pc/instr_valid- fetched word presented downstream
//   instr_ready               - consumer finished current instruction
//   redirect/redirect_target  - taken-branch next PC, valid with instr_ready
// Modports: master = fetch unit side, slave = memory/consumer side.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_ack;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ack,
        output instr, instr_pc, instr_valid,
        input  instr_ready, redirect, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ack,
        input  instr, instr_pc, instr_valid,
        output instr_ready, redirect, redirect_target
    );

endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues one req/ack read
// per instruction, holds the fetched word until the consumer retires it,
// applies branch redirects at retirement and stops on the halt word, an
// illegal PC or an ack timeout.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   bus       - fetch_unit_if.master (memory bus + instruction hand-off)
//   halted    - sticky: fetch has stopped
//   fault     - sticky: stop was caused by an error
//   retired   - number of accepted instructions (wraps)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS  = 32,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    fetch_unit_if.master     bus,
    output logic             halted,
    output logic             fault,
    output logic [XLEN-1:0]  retired
);

    localparam logic [XLEN-1:0] IMEM_BYTES   = XLEN'(IMEM_WORDS * 4);
    localparam logic [7:0]      TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    state_e          state_q,    state_d;
    logic [XLEN-1:0] pc_q,       pc_d;
    logic [XLEN-1:0] instr_q,    instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            valid_q,    valid_d;
    logic            req_q,      req_d;
    logic            halted_q,   halted_d;
    logic            fault_q,    fault_d;
    logic [XLEN-1:0] retired_q,  retired_d;
    logic [7:0]      cnt_q,      cnt_d;

    // Next-state and next-output logic of the fetch FSM.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        req_d      = req_q;
        halted_d   = halted_q;
        fault_d    = fault_q;
        retired_d  = retired_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_FETCH: begin
                if (!req_q) begin
                    // Entry check: an illegal PC never reaches the memory bus.
                    if ((pc_q[1:0] != 2'b00) || (pc_q >= IMEM_BYTES)) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                        fault_d  = 1'b1;
                    end else begin
                        req_d = 1'b1;
                    end
                end else if (bus.imem_ack) begin
                    instr_d    = bus.imem_rdata;
                    instr_pc_d = pc_q;
                    req_d      = 1'b0;
                    cnt_d      = 8'd0;
                    if (bus.imem_rdata == HALT_INSTR) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        valid_d = 1'b1;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // This waiting cycle brings the count to ACK_TIMEOUT.
                    state_d  = ST_HALT;
                    req_d    = 1'b0;
                    halted_d = 1'b1;
                    fault_d  = 1'b1;
                    cnt_d    = cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (bus.instr_ready) begin
                    valid_d   = 1'b0;
                    retired_d = retired_q + 32'd1;
                    pc_d      = bus.redirect ? bus.redirect_target : (pc_q + 32'd4);
                    state_d   = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HALT: begin
                req_d    = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                state_d  = ST_HALT;
                req_d    = 1'b0;
                valid_d  = 1'b0;
                halted_d = 1'b1;
                fault_d  = 1'b1;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0000_0000;
            instr_pc_q <= 32'h0000_0000;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
            retired_q  <= 32'h0000_0000;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            req_q      <= req_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
            retired_q  <= retired_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;
    assign halted          = halted_q;
    assign fault           = fault_q;
    assign retired         = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. Inputs are driven and outputs
// sampled on the falling clock edge; the memory is emulated by the serve task.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        halted;
    logic        fault;
    logic [31:0] retired;
    int          total = 0;
    int          bad   = 0;
    int          n;

    fetch_unit_if bus();

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (32),
        .ACK_TIMEOUT(15)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .halted (halted),
        .fault  (fault),
        .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst                 = 1'b1;
        bus.imem_ack        = 1'b0;
        bus.imem_rdata      = 32'h0;
        bus.instr_ready     = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) for imem_req; a missing request is a failed comparison.
    task automatic wait_req(input string tag);
        int k;
        k = 0;
        while (!bus.imem_req && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_req"}, 32'(bus.imem_req), 32'd1);
    endtask

    // Memory: answers the next request after 'lag' cycles with 'data'.
    task automatic serve(input string tag, input logic [31:0] exp_addr,
                         input int lag, input logic [31:0] data);
        wait_req(tag);
        chk({tag, "_addr"}, bus.imem_addr, exp_addr);
        repeat (lag) @(negedge clk);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
    endtask

    task automatic accept(input logic redir, input logic [31:0] tgt);
        bus.instr_ready     = 1'b1;
        bus.redirect        = redir;
        bus.redirect_target = tgt;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        rst                 = 1'b1;
        bus.imem_ack        = 1'b0;
        bus.imem_rdata      = 32'h0;
        bus.instr_ready     = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = 32'h0;
        @(negedge clk);
        chk("rst_req",     32'(bus.imem_req),    32'd0);
        chk("rst_valid",   32'(bus.instr_valid), 32'd0);
        chk("rst_halted",  32'(halted),          32'd0);
        chk("rst_fault",   32'(fault),           32'd0);
        chk("rst_retired", retired,              32'd0);
        chk("rst_instr",   bus.instr,            32'd0);
        chk("rst_ipc",     bus.instr_pc,         32'd0);
        chk("rst_addr",    bus.imem_addr,        32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait program: addi, addi, halt word
        serve("t1a", 32'h0, 1, 32'h0010_0093);
        chk("t1a_valid", 32'(bus.instr_valid), 32'd1);
        chk("t1a_instr", bus.instr,            32'h0010_0093);
        chk("t1a_ipc",   bus.instr_pc,         32'h0);
        chk("t1a_reqlo", 32'(bus.imem_req),    32'd0);
        repeat (3) @(negedge clk);
        chk("t1a_hold",  32'(bus.instr_valid), 32'd1);
        accept(1'b0, 32'h0);
        chk("t1a_drop",  32'(bus.instr_valid), 32'd0);
        chk("t1a_ret",   retired,              32'd1);
        serve("t1b", 32'h4, 1, 32'h0020_0113);
        chk("t1b_valid", 32'(bus.instr_valid), 32'd1);
        chk("t1b_instr", bus.instr,            32'h0020_0113);
        repeat (3) @(negedge clk);
        accept(1'b0, 32'h0);
        chk("t1b_ret",   retired,              32'd2);
        serve("t1c", 32'h8, 1, HALT_INSTR);
        chk("t1c_valid",  32'(bus.instr_valid), 32'd0);
        chk("t1c_halted", 32'(halted),          32'd1);
        chk("t1c_fault",  32'(fault),           32'd0);
        chk("t1c_req",    32'(bus.imem_req),    32'd0);
        repeat (3) @(negedge clk);
        chk("t1c_valid2", 32'(bus.instr_valid), 32'd0);
        chk("t1c_halt2",  32'(halted),          32'd1);
        chk("t1c_ret",    retired,              32'd2);

        // Ack delayed 5 cycles: request held stable for 6 cycles
        do_reset();
        wait_req("t2");
        for (int i = 0; i < 5; i++) begin
            chk("t2_req_hold",  32'(bus.imem_req), 32'd1);
            chk("t2_addr_hold", bus.imem_addr,     32'h0);
            @(negedge clk);
        end
        chk("t2_req_last", 32'(bus.imem_req),    32'd1);
        chk("t2_pre_val",  32'(bus.instr_valid), 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        chk("t2_valid", 32'(bus.instr_valid), 32'd1);
        chk("t2_instr", bus.instr,            32'h1234_5678);
        chk("t2_reqlo", 32'(bus.imem_req),    32'd0);

        // Stray ack while holding is ignored
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hdead_beef;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        chk("stray_instr", bus.instr,            32'h1234_5678);
        chk("stray_valid", 32'(bus.instr_valid), 32'd1);
        chk("stray_fault", 32'(fault),           32'd0);

        // Redirects
        accept(1'b1, 32'h10);
        chk("t3_ret1", retired, 32'd1);
        serve("t3a", 32'h10, 1, 32'h0030_0193);
        chk("t3a_ipc", bus.instr_pc, 32'h10);
        bus.redirect        = 1'b1;
        bus.redirect_target = 32'h40;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk("t3_noacc_valid", 32'(bus.instr_valid), 32'd1);
        chk("t3_noacc_req",   32'(bus.imem_req),    32'd0);
        chk("t3_noacc_ret",   retired,              32'd1);
        accept(1'b1, 32'h4);
        serve("t3b", 32'h4, 1, 32'h0040_0213);
        chk("t3b_ipc", bus.instr_pc, 32'h4);
        chk("t3b_ret", retired,      32'd2);

        // Misaligned target faults without a request
        accept(1'b1, 32'h6);
        chk("t4_ret",     retired,          32'd3);
        chk("t4_req0",    32'(bus.imem_req), 32'd0);
        chk("t4_halt0",   32'(halted),       32'd0);
        @(negedge clk);
        chk("t4_req1",    32'(bus.imem_req), 32'd0);
        chk("t4_halted",  32'(halted),       32'd1);
        chk("t4_fault",   32'(fault),        32'd1);
        chk("t4_addr",    bus.imem_addr,     32'h6);
        repeat (3) @(negedge clk);
        chk("t4_req2",    32'(bus.imem_req), 32'd0);

        // Target at end of memory faults
        do_reset();
        serve("t5", 32'h0, 1, 32'h0010_0093);
        accept(1'b1, 32'h80);
        @(negedge clk);
        chk("t5_fault",  32'(fault),        32'd1);
        chk("t5_halted", 32'(halted),       32'd1);
        chk("t5_req",    32'(bus.imem_req), 32'd0);

        // Ack never returns: timeout after exactly 15 request cycles
        do_reset();
        wait_req("t6");
        n = 0;
        while (bus.imem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("t6_cycles", 32'(n),           32'd15);
        chk("t6_fault",  32'(fault),        32'd1);
        chk("t6_halted", 32'(halted),       32'd1);
        chk("t6_req",    32'(bus.imem_req), 32'd0);

        // Asynchronous reset while holding an instruction
        do_reset();
        serve("t7a", 32'h0, 1, 32'h0010_0093);
        accept(1'b0, 32'h0);
        serve("t7b", 32'h4, 1, 32'h0050_0293);
        chk("t7_valid_pre", 32'(bus.instr_valid), 32'd1);
        chk("t7_ret_pre",   retired,              32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_valid_rst", 32'(bus.instr_valid), 32'd0);
        chk("t7_ret_rst",   retired,              32'd0);
        chk("t7_addr_rst",  bus.imem_addr,        32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_req("t7c");
        chk("t7c_addr", bus.imem_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the decoder and the multi-cycle control FSM. It owns the PC and issues req/ack reads to instruction memory. It presents each fetched word with a valid/ready handshake, applies branch redirects at instruction retirement, and stops on the all-zero halt word or on a fetch fault. It replaces the free-running PC/read pair with an explicit handshake so memory latency is no longer hard-coded into delay states.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
IMEM_WORDS, 32, instruction memory depth in 32-bit words; legal byte addresses are 0 to IMEM_WORDS*4-4.
ACK_TIMEOUT, 15, maximum cycles to wait for imem_ack before a fault (1..255).

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
imem_req  out  1  read request to instruction memory.
imem_addr  out  32  byte address of the request; equals pc.
imem_rdata  in  32  instruction word; valid in the cycle imem_ack=1.
imem_ack  in  1  one-cycle read completion.
instr  out  32  fetched instruction, held stable while instr_valid=1.
instr_pc  out  32  address of instr.
instr_valid  out  1  instr is available to the consumer.
instr_ready  in  1  consumer has finished the current instruction (one-cycle pulse).
redirect  in  1  branch taken; sampled only on accept.
redirect_target  in  32  next PC when redirect=1.
halted  out  1  fetch has stopped (sticky until reset).
fault  out  1  halt caused by an error, not by the halt word (sticky).
retired  out  32  count of accepted instructions.

Behaviour:
- Reset (async, immediate): state=FETCH, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, imem_req=0, halted=0, fault=0, retired=0, timeout counter=0.
- imem_req is registered. It goes to 1 on the first clock edge after rst deasserts.
- States: FETCH, HOLD, HALT. Encoding is in the package.
- FETCH entry check: if pc[1:0]!=0 or pc>=IMEM_WORDS*4, go to HALT with fault=1 and never assert imem_req.
- FETCH: imem_req=1, imem_addr=pc, both stable until ack. The counter increments each cycle without ack.
- FETCH, counter reaches ACK_TIMEOUT: go to HALT, fault=1, imem_req=0.
- FETCH, imem_ack=1: capture instr=imem_rdata and instr_pc=pc, clear imem_req and the counter.
  - If imem_rdata==32'h0: go to HALT, halted=1, fault=0, instr_valid stays 0.
  - Otherwise: go to HOLD, instr_valid=1 from the next cycle.
- Fetch latency: ack to instr_valid is one cycle. Minimum request-to-valid is 2 cycles with a zero-wait memory.
- HOLD: instr_valid=1; instr and instr_pc are frozen. On instr_ready=1:
  - instr_valid=0 next cycle; retired increments by 1 (wraps mod 2^32).
  - pc becomes redirect_target if redirect=1, else pc+4 (mod 2^32 wrap, then range-checked in FETCH).
  - State goes to FETCH.
- redirect outside an accepting cycle is ignored. instr_ready outside HOLD is ignored.
- imem_ack outside FETCH is ignored (stray ack). It neither captures data nor faults.
- HALT: absorbing state. All outputs hold, imem_req=0, halted=1. Only rst leaves it.
- Reset mid-fetch: the outstanding request is abandoned. A late ack after rst release arrives in FETCH with the counter at 0 and is treated as a valid response, so the memory must drop ack under rst.
- halted=1 is set whenever HALT is entered, including on faults.

Decomposition:
- Shared package: the state enum {FETCH, HOLD, HALT}, the HALT_INSTR=32'h0 constant, and the XLEN=32 constant. The package is shared with the control FSM so it decodes the same halt word.
- No sub-module; the timeout counter is inline.

Test Plan:
- Zero-wait memory holding addi at 0x0 and 0x4, then 0x0 at 0x8; instr_ready pulsed 3 cycles after each valid -> fetch addresses 0x0, 0x4, 0x8; retired=2; halted=1, fault=0; instr_valid never high for 0x8.
- Ack delayed 5 cycles -> imem_req and imem_addr=0x0 stable for 6 cycles; instr_valid rises exactly 1 cycle after ack; instr=imem_rdata.
- Accept at pc=0x10 with redirect=1, redirect_target=0x4 -> next imem_addr=0x4. Redirect=1 pulsed during HOLD without ready -> no effect.
- redirect_target=0x6 -> HALT with fault=1, no imem_req. Target=0x80 with IMEM_WORDS=32 -> fault=1.
- Ack never returns -> fault=1, halted=1, imem_req=0 exactly ACK_TIMEOUT cycles after the request rises.
- Assert rst during HOLD with instr_valid=1 -> instr_valid=0 and retired=0 immediately; the first request after release is at RESET_PC.
